// File: rtl/button_debouncer.sv
// Two-channel (up/down) push-button debouncer: 2-flop synchronizer, 4-state qualify FSM, registered level and press pulse.
// Optional auto-repeat of the press pulse is built only when the AUTO_REPEAT_EN macro is defined.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_LIMIT = 250000,
  parameter int unsigned REPEAT_DELAY   = 12500000,
  parameter int unsigned REPEAT_PERIOD  = 2500000
) (
  input  logic CLK,
  input  logic i_Reset,
  input  logic i_Up_Button_Raw,
  input  logic i_Down_Button_Raw,
  output logic o_Up_Level,
  output logic o_Down_Level,
  output logic o_Up_Pulse,
  output logic o_Down_Pulse
);

  localparam int unsigned NUM_CH  = 2;
  localparam int unsigned CH_UP   = 0;
  localparam int unsigned CH_DOWN = 1;
  localparam int unsigned CNT_W   = $clog2(DEBOUNCE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);

  // Elaboration-time parameter sanity checks.
  if (DEBOUNCE_LIMIT < 2) begin : g_bad_limit
    $error("button_debouncer: DEBOUNCE_LIMIT must be >= 2");
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
    $error("button_debouncer: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  typedef enum logic [1:0] {
    S_LOW       = 2'd0,
    S_QUAL_HIGH = 2'd1,
    S_HIGH      = 2'd2,
    S_QUAL_LOW  = 2'd3
  } state_e;

  logic [NUM_CH-1:0] raw_c;
  logic [NUM_CH-1:0] level_vec;
  logic [NUM_CH-1:0] pulse_vec;

  assign raw_c = {i_Down_Button_Raw, i_Up_Button_Raw};

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    logic               sync_meta;
    logic               sync_q;
    state_e             state_q;
    state_e             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               level_d;
    logic               rise_c;
    logic               pulse_d;
    logic               level_q;
    logic               pulse_q;

    // Two-flop synchronizer for the asynchronous contact.
    always_ff @(posedge CLK) begin
      if (i_Reset) begin
        sync_meta <= 1'b0;
        sync_q    <= 1'b0;
      end else begin
        sync_meta <= raw_c[ch];
        sync_q    <= sync_meta;
      end
    end

    always_ff @(posedge CLK) begin
      if (i_Reset) begin
        state_q <= S_LOW;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    // Counter is zero in stable states and restarts whenever a QUAL state is (re)entered.
    always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      unique case (state_q)
        S_LOW: begin
          if (sync_q) state_d = S_QUAL_HIGH;
        end
        S_QUAL_HIGH: begin
          if (!sync_q)                state_d = S_LOW;
          else if (cnt_q == CNT_LAST) state_d = S_HIGH;
          else                        cnt_d   = cnt_q + CNT_W'(1);
        end
        S_HIGH: begin
          if (!sync_q) state_d = S_QUAL_LOW;
        end
        S_QUAL_LOW: begin
          if (sync_q)                 state_d = S_HIGH;
          else if (cnt_q == CNT_LAST) state_d = S_LOW;
          else                        cnt_d   = cnt_q + CNT_W'(1);
        end
        default: begin
          state_d = S_LOW;
        end
      endcase
    end

    assign level_d = (state_d == S_HIGH) || (state_d == S_QUAL_LOW);
    assign rise_c  = level_d & ~level_q;

`ifdef AUTO_REPEAT_EN
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);

    logic [RPT_W-1:0] rpt_cnt_q;
    logic [RPT_W-1:0] rpt_target_c;
    logic             rpt_first_q;
    logic             rpt_hold_c;
    logic             rpt_hit_c;

    // Cycles since the last emitted pulse; first interval is the delay, later ones the period.
    assign rpt_hold_c   = level_q & level_d;
    assign rpt_target_c = rpt_first_q ? RPT_W'(REPEAT_DELAY) : RPT_W'(REPEAT_PERIOD);
    assign rpt_hit_c    = rpt_hold_c && ((rpt_cnt_q + RPT_W'(1)) == rpt_target_c);

    always_ff @(posedge CLK) begin
      if (i_Reset || !rpt_hold_c) begin
        rpt_cnt_q   <= '0;
        rpt_first_q <= 1'b1;
      end else if (rpt_hit_c) begin
        rpt_cnt_q   <= '0;
        rpt_first_q <= 1'b0;
      end else begin
        rpt_cnt_q   <= rpt_cnt_q + RPT_W'(1);
      end
    end

    assign pulse_d = rise_c | rpt_hit_c;
`else
    assign pulse_d = rise_c;
`endif

    always_ff @(posedge CLK) begin
      if (i_Reset) begin
        level_q <= 1'b0;
        pulse_q <= 1'b0;
      end else begin
        level_q <= level_d;
        pulse_q <= pulse_d;
      end
    end

    assign level_vec[ch] = level_q;
    assign pulse_vec[ch] = pulse_q;
  end

  assign o_Up_Level   = level_vec[CH_UP];
  assign o_Down_Level = level_vec[CH_DOWN];
  assign o_Up_Pulse   = pulse_vec[CH_UP];
  assign o_Down_Pulse = pulse_vec[CH_DOWN];

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer: directed scenarios plus random bounce, against a run-length reference model.
module tb_button_debouncer;

  localparam int unsigned L = 4;
  localparam int unsigned D = 10;
  localparam int unsigned P = 5;

  logic CLK = 1'b0;
  logic i_Reset;
  logic i_Up_Button_Raw;
  logic i_Down_Button_Raw;
  logic o_Up_Level;
  logic o_Down_Level;
  logic o_Up_Pulse;
  logic o_Down_Pulse;

  always #5 CLK = ~CLK;

  button_debouncer #(
    .DEBOUNCE_LIMIT(L),
    .REPEAT_DELAY  (D),
    .REPEAT_PERIOD (P)
  ) dut (
    .CLK              (CLK),
    .i_Reset          (i_Reset),
    .i_Up_Button_Raw  (i_Up_Button_Raw),
    .i_Down_Button_Raw(i_Down_Button_Raw),
    .o_Up_Level       (o_Up_Level),
    .o_Down_Level     (o_Down_Level),
    .o_Up_Pulse       (o_Up_Pulse),
    .o_Down_Pulse     (o_Down_Pulse)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model state per channel (0 = up, 1 = down).
  bit m_s1[2];
  bit m_s2[2];
  bit m_lvl[2];
  bit m_pls[2];
  int m_run[2];
  int m_hold[2];

  // Observation bookkeeping.
  int  up_pulses, dn_pulses, up_last, dn_last, both_cyc, up_rise, up_fall;
  logic prev_up_level;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Level flips once L+1 consecutive synchronized samples disagree with it.
  task automatic model_ch(input int c, input bit rst, input bit raw);
    bit smp;
    if (rst) begin
      m_s1[c] = 0; m_s2[c] = 0; m_lvl[c] = 0; m_pls[c] = 0; m_run[c] = 0; m_hold[c] = 0;
      return;
    end
    smp     = m_s2[c];
    m_s2[c] = m_s1[c];
    m_s1[c] = raw;
    m_pls[c] = 0;
    if (smp != m_lvl[c]) m_run[c]++;
    else                 m_run[c] = 0;
    if (m_run[c] == int'(L) + 1) begin
      m_lvl[c] = smp;
      m_run[c] = 0;
      if (smp) begin
        m_pls[c]  = 1;
        m_hold[c] = 0;
      end
    end else if (m_lvl[c]) begin
`ifdef AUTO_REPEAT_EN
      m_hold[c]++;
      if (m_hold[c] == int'(D) || (m_hold[c] > int'(D) && (m_hold[c] - int'(D)) % int'(P) == 0))
        m_pls[c] = 1;
`endif
    end
  endtask

  task automatic cycle(input bit rst, input bit u, input bit d);
    i_Reset           = rst;
    i_Up_Button_Raw   = u;
    i_Down_Button_Raw = d;
    @(posedge CLK);
    model_ch(0, rst, u);
    model_ch(1, rst, d);
    cyc++;
    @(negedge CLK);
    chk("up_level",   o_Up_Level,   m_lvl[0]);
    chk("down_level", o_Down_Level, m_lvl[1]);
    chk("up_pulse",   o_Up_Pulse,   m_pls[0]);
    chk("down_pulse", o_Down_Pulse, m_pls[1]);
    if (o_Up_Pulse === 1'b1)   begin up_pulses++; up_last = cyc; end
    if (o_Down_Pulse === 1'b1) begin dn_pulses++; dn_last = cyc; end
    if (o_Up_Pulse === 1'b1 && o_Down_Pulse === 1'b1) both_cyc = cyc;
    if (prev_up_level === 1'b0 && o_Up_Level === 1'b1) up_rise = cyc;
    if (prev_up_level === 1'b1 && o_Up_Level === 1'b0) up_fall = cyc;
    prev_up_level = o_Up_Level;
  endtask

  task automatic run(input bit rst, input bit u, input bit d, input int n);
    for (int i = 0; i < n; i++) cycle(rst, u, d);
  endtask

  task automatic clear_obs();
    up_pulses = 0; dn_pulses = 0; up_last = -1; dn_last = -1;
    both_cyc = -1; up_rise = -1; up_fall = -1;
  endtask

  initial begin
    int start;
    int exp_pulses;
    bit rv[2];
    int rl[2];

    i_Reset = 1'b1; i_Up_Button_Raw = 1'b1; i_Down_Button_Raw = 1'b1;
    prev_up_level = 1'b0;
    clear_obs();

    // Reset held with buttons pressed, then one pulse per button after release.
    run(1, 1, 1, 2);
    chk("reset_up_level",   o_Up_Level,   0);
    chk("reset_down_level", o_Down_Level, 0);
    chk("reset_up_pulse",   o_Up_Pulse,   0);
    chk("reset_down_pulse", o_Down_Pulse, 0);
    clear_obs();
    start = cyc + 1;
    run(0, 1, 1, 9);
    chk("release_pulse_delay", up_last - start, 6);
    chk("release_pulse_count", up_pulses, 1);
    chk("release_down_same_cycle", both_cyc, up_last);
    run(0, 0, 0, 10);

    // Clean press and release.
    clear_obs();
    start = cyc + 1;
    run(0, 1, 0, 20);
`ifdef AUTO_REPEAT_EN
    exp_pulses = 2;
`else
    exp_pulses = 1;
`endif
    chk("clean_rise_delay", up_rise - start, 6);
    chk("clean_pulse_at_rise", up_last >= up_rise ? up_rise : -1, up_rise);
    run(0, 0, 0, 10);
    chk("clean_fall_delay", up_fall - (start + 20), 6);
`ifdef AUTO_REPEAT_EN
    exp_pulses = 3;
`endif
    chk("clean_no_release_pulse", up_pulses, exp_pulses);

    // Short glitch and bounce train, then steady press.
    clear_obs();
    run(0, 1, 0, 3);
    run(0, 0, 0, 6);
    cycle(0, 1, 0); cycle(0, 0, 0); cycle(0, 1, 0); cycle(0, 0, 0);
    chk("glitch_no_pulse", up_pulses, 0);
    start = cyc + 1;
    run(0, 1, 0, 12);
    chk("bounce_pulse_delay", up_last - start, 6);
    chk("bounce_pulse_count", up_pulses, 1);
    run(0, 0, 0, 10);

    // Both buttons qualify on the same edge.
    clear_obs();
    start = cyc + 1;
    run(0, 1, 1, 10);
    chk("simul_both_delay", both_cyc - start, 6);
    chk("simul_same_cycle", dn_last, up_last);
    run(0, 0, 0, 10);

    // Reset in the middle of qualification discards the partial count.
    clear_obs();
    run(0, 1, 0, 3);
    cycle(1, 1, 0);
    start = cyc + 1;
    run(0, 1, 0, 10);
    chk("midreset_pulse_count", up_pulses, 1);
    chk("midreset_pulse_delay", up_last - start, 6);
    run(0, 0, 0, 10);

    // Long hold: repeats only when auto-repeat is built in.
    clear_obs();
    start = cyc + 1;
    run(0, 1, 0, 40);
`ifdef AUTO_REPEAT_EN
    exp_pulses = 6;
`else
    exp_pulses = 1;
`endif
    chk("hold_pulse_count", up_pulses, exp_pulses);
    run(0, 0, 0, 12);

    // Random bounce runs with occasional reset.
    rv[0] = 0; rv[1] = 0; rl[0] = 0; rl[1] = 0;
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < 2; c++) begin
        if (rl[c] == 0) begin
          rv[c] = bit'($urandom_range(0, 1));
          rl[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(6, 30)) : int'($urandom_range(1, 6));
        end
        rl[c]--;
      end
      cycle(($urandom_range(0, 199) == 0), rv[0], rv[1]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
